if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 76 +++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register plus IF/ID pipeline register.
// Flush takes priority over pause, and pause takes priority over a normal fetch.
module if_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        pause_flag,
    input  logic        flush_flag,
    input  logic [31:0] ex_npc,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_rdata,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic [31:0] fetch_cnt,
    output logic        misalign_err
);

    localparam int unsigned XLEN     = 32;
    localparam logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] RST_PC   = '0;
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] CNT_MAX  = '1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next_seq;
    logic [XLEN-1:0] redirect_pc;
    logic            normal_cycle;

    assign inst_addr    = pc;
    assign pc_next_seq  = pc + PC_STEP;
    assign redirect_pc  = {ex_npc[XLEN-1:2], 2'b00};
    assign normal_cycle = !flush_flag && !pause_flag;

    // PC and IF/ID register update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc       <= RST_PC;
            id_pc    <= '0;
            id_pc4   <= '0;
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else if (flush_flag) begin
            pc       <= redirect_pc;
            id_pc    <= '0;
            id_pc4   <= '0;
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else if (!pause_flag) begin
            pc       <= pc_next_seq;
            id_pc    <= pc;
            id_pc4   <= pc_next_seq;
            id_inst  <= inst_rdata;
            id_valid <= 1'b1;
        end
    end

    // Committed-fetch counter, saturating at all ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_cnt <= '0;
        end else if (normal_cycle && (fetch_cnt != CNT_MAX)) begin
            fetch_cnt <= fetch_cnt + XLEN'(1);
        end
    end

    // Sticky flag for redirect targets that were not word aligned.
    always_ff @(posedge clk) begin
        if (!rst) begin
            misalign_err <= 1'b0;
        end else if (flush_flag && (ex_npc[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end
    end

endmodule
